// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - stopwatch state encoding and default timing constants
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_TICK_DIV        = 5000000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - raw button synchronizer, debouncer and rising-edge press pulse
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q, press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM with debounced buttons and tick prescaler
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       tick,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state
);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic             ss_ev, lap_ev, clr_ev;
  logic             running;
  sw_state_e        state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             clear_q, clear_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .rst(rst), .btn_i(btn_ss), .press_o(ss_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .btn_i(btn_lap), .press_o(lap_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .btn_i(btn_clr), .press_o(clr_ev)
  );

  assign running = (state_q == S_RUN) || (state_q == S_LAP);

  // clr outranks ss only where clr is legal, so an illegal clr never masks ss.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_ev)     clear_d = 1'b1;
        else if (ss_ev) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_ev)       state_d = S_PAUSE;
        else if (lap_ev) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_ev)       state_d = S_PAUSE;
        else if (lap_ev) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clr_ev) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end else if (ss_ev) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler holds through PAUSE so a resume continues mid-period.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_d == S_IDLE) begin
      presc_d = '0;
    end else if (running) begin
      if (presc_q == PRE_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  assign tick   = tick_q;
  assign clear  = clear_q;
  assign freeze = (state_q == S_LAP);
  assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with behavioural model
module tb_stopwatch_ctrl;
  localparam int DEB  = 4;
  localparam int TDIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_lap, btn_clr;
  logic       tick, clear, freeze;
  logic [1:0] state;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .tick(tick), .clear(clear), .freeze(freeze), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tick_seen = 0;
  int clear_seen = 0;

  // Model: states 0 idle, 1 run, 2 pause, 3 lap; buttons 0 ss, 1 lap, 2 clr.
  int m_state = 0;
  int m_phase = 0;
  bit m_tick = 0;
  bit m_clear = 0;
  int m_run[3];
  bit m_lvl[3];
  int m_due[3];

  function automatic void model_edge(input bit r, input bit [2:0] raw);
    bit [2:0] ev;
    if (r) begin
      m_state = 0; m_phase = 0; m_tick = 0; m_clear = 0;
      for (int b = 0; b < 3; b++) begin
        m_run[b] = 0; m_lvl[b] = 0; m_due[b] = -1;
      end
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = (m_due[b] == cyc);
      if (ev[b]) m_due[b] = -1;
    end
    m_tick = 0;
    m_clear = 0;
    if (m_state == 1 || m_state == 3) begin
      m_phase = (m_phase + 1) % TDIV;
      m_tick = (m_phase == 0);
    end
    case (m_state)
      0: if (ev[2]) m_clear = 1; else if (ev[0]) m_state = 1;
      1: if (ev[0]) m_state = 2; else if (ev[1]) m_state = 3;
      3: if (ev[0]) m_state = 2; else if (ev[1]) m_state = 1;
      default: if (ev[2]) begin m_state = 0; m_clear = 1; end else if (ev[0]) m_state = 1;
    endcase
    if (m_state == 0) m_phase = 0;
    // A raw level accepted after DEB consecutive differing samples acts 4 edges later.
    for (int b = 0; b < 3; b++) begin
      if (raw[b] == m_lvl[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = raw[b];
          m_run[b] = 0;
          if (raw[b]) m_due[b] = cyc + 4;
        end
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(rst, {btn_clr, btn_lap, btn_ss});
    #1;
    check("state", int'(state), m_state);
    check("tick", int'(tick), int'(m_tick));
    check("clear", int'(clear), int'(m_clear));
    check("freeze", int'(freeze), (m_state == 3) ? 1 : 0);
    check("tick_clear_exclusive", int'(tick & clear), 0);
    if (tick) tick_seen++;
    if (clear) clear_seen++;
  endtask

  task automatic wait_state(input int want, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (int'(state) == want) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("wait_state_timeout", int'(state), want);
  endtask

  task automatic wait_tick(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (tick) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("wait_tick_timeout", 0, 1);
  endtask

  task automatic press(input bit [2:0] m);
    {btn_clr, btn_lap, btn_ss} = m;
    repeat (8) step();
    {btn_clr, btn_lap, btn_ss} = 3'b000;
    repeat (8) step();
  endtask

  int c0, at, t1, t2;
  logic [5:0] bounce;

  initial begin
    for (int b = 0; b < 3; b++) m_due[b] = -1;
    rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check("reset_state", int'(state), 0);
    check("reset_outputs", int'({tick, clear, freeze}), 0);

    // Clean start press: latency and tick cadence.
    btn_ss = 1'b1;
    c0 = cyc + 1;
    wait_state(1, 20, at);
    check("ss_to_run_latency", at - c0, 7);
    wait_tick(20, t1);
    check("first_tick_after_run", t1 - at, 10);
    wait_tick(20, t2);
    check("tick_period", t2 - t1, 10);
    btn_ss = 1'b0;
    repeat (8) step();

    // Bouncy press gives one event; a short pulse gives none.
    bounce = 6'b110011;
    for (int i = 0; i < 6; i++) begin
      btn_ss = bounce[5 - i];
      step();
    end
    btn_ss = 1'b1; repeat (10) step();
    btn_ss = 1'b0; repeat (10) step();
    check("bounce_one_event", int'(state), 2);
    btn_ss = 1'b1; repeat (3) step();
    btn_ss = 1'b0; repeat (10) step();
    check("short_pulse_ignored", int'(state), 2);

    // Pause with prescaler at 6, resume 50+ cycles later.
    press(3'b001);
    check("resumed_run", int'(state), 1);
    for (int i = 0; i < TDIV && m_phase != 8; i++) step();
    press(3'b001);
    check("paused", int'(state), 2);
    tick_seen = 0;
    repeat (50) step();
    check("no_tick_in_pause", tick_seen, 0);
    btn_ss = 1'b1;
    wait_state(1, 20, at);
    wait_tick(20, t1);
    check("resume_first_tick", t1 - at, 4);
    btn_ss = 1'b0;
    repeat (8) step();

    // Lap freezes display while ticks continue.
    press(3'b010);
    check("lap_state", int'(state), 3);
    check("lap_freeze", int'(freeze), 1);
    tick_seen = 0;
    repeat (20) step();
    check("ticks_during_lap", tick_seen, 2);
    press(3'b010);
    check("lap_exit_state", int'(state), 1);
    check("lap_exit_freeze", int'(freeze), 0);

    // Clear beats ss in PAUSE; clear in IDLE pulses; clr in RUN ignored.
    press(3'b001);
    check("pause_before_clr", int'(state), 2);
    clear_seen = 0;
    press(3'b101);
    check("clr_ss_state", int'(state), 0);
    check("clr_ss_pulses", clear_seen, 1);
    clear_seen = 0;
    press(3'b100);
    check("idle_clr_pulse", clear_seen, 1);
    press(3'b010);
    check("idle_lap_ignored", int'(state), 0);
    press(3'b001);
    clear_seen = 0;
    press(3'b100);
    check("run_clr_ignored_state", int'(state), 1);
    check("run_clr_no_pulse", clear_seen, 0);

    // Reset mid-run at prescaler 5.
    for (int i = 0; i < TDIV && m_phase != 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_outputs", int'({tick, clear, freeze}), 0);
    btn_ss = 1'b1;
    wait_state(1, 20, at);
    wait_tick(20, t1);
    check("post_rst_first_tick", t1 - at, 10);
    btn_ss = 1'b0;
    repeat (8) step();

    // Button held through reset yields exactly one press after release.
    rst = 1'b1; btn_ss = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("held_rst_state", int'(state), 0);
    repeat (15) step();
    check("held_through_rst_event", int'(state), 1);
    btn_ss = 1'b0;
    repeat (10) step();
    check("held_through_rst_single", int'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
